// File: rtl/rfile_pkg.sv
// rfile_pkg -- shared types and helpers for the multi-port register file.
//
// Contents:
//   rf_state_t : controller state (RF_INIT while the array is being cleared,
//                RF_READY once every register holds a defined value).
//   clog2()    : constant-foldable ceiling log2, used to size address buses
//                from NREGS.
package rfile_pkg;

  typedef enum logic {
    RF_INIT  = 1'b0,
    RF_READY = 1'b1
  } rf_state_t;

  // Ceiling log2. Callers pass a power of two, where this is the exact log2.
  function automatic int clog2(input int value);
    int result;
    int v;
    result = 0;
    v      = value - 1;
    while (v > 0) begin
      result = result + 1;
      v      = v >> 1;
    end
    return result;
  endfunction

endpackage : rfile_pkg

// File: rtl/rfile_scoreboard.sv
// rfile_scoreboard -- per-register "result in flight" bits for rfile_mp.
//
// Ports:
//   clk          in  core clock
//   reset        in  synchronous active-high reset, clears every pending bit
//   set_en       in  claim strobe: mark set_addr pending
//   set_addr     in  AW   register being claimed
//   clr_en       in  write strobe: the result for clr_addr has arrived
//   clr_addr     in  AW   register being written
//   lookup_addr  in  NRD*AW packed lookup addresses, port i at [i*AW +: AW]
//   lookup_pend  out NRD  pending bit of each lookup address (combinational)
//
// A claim and a write to the same register in one cycle leave the bit set:
// the claim belongs to a newer instruction than the result being written.
// With ZERO_REG set, register 0 can never become pending.
module rfile_scoreboard
  import rfile_pkg::*;
#(
  parameter int NREGS    = 32,
  parameter int NRD      = 2,
  parameter int ZERO_REG = 1,
  localparam int AW      = clog2(NREGS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              set_en,
  input  logic [AW-1:0]     set_addr,
  input  logic              clr_en,
  input  logic [AW-1:0]     clr_addr,
  input  logic [NRD*AW-1:0] lookup_addr,
  output logic [NRD-1:0]    lookup_pend
);

  logic [NREGS-1:0] pend_reg;
  logic [NREGS-1:0] pend_next;

  genvar gi;

  // Next value of each pending bit, one small equation per register.
  generate
    for (gi = 0; gi < NREGS; gi++) begin : g_bit
      if ((ZERO_REG != 0) && (gi == 0)) begin : g_zero
        assign pend_next[gi] = 1'b0;
      end else begin : g_live
        logic set_hit;
        logic clr_hit;
        assign set_hit       = set_en & (set_addr == AW'(gi));
        assign clr_hit       = clr_en & (clr_addr == AW'(gi));
        // Set has priority over clear.
        assign pend_next[gi] = set_hit | (pend_reg[gi] & ~clr_hit);
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      pend_reg <= '0;
    end else begin
      pend_reg <= pend_next;
    end
  end

  generate
    for (gi = 0; gi < NRD; gi++) begin : g_lookup
      assign lookup_pend[gi] = pend_reg[lookup_addr[gi*AW +: AW]];
    end
  endgenerate

endmodule : rfile_scoreboard

// File: rtl/rfile_mp.sv
// rfile_mp -- multi-port integer register file with write bypass, pending
// scoreboard and a post-reset clear sequencer.
//
// Ports:
//   clk         in  core clock, all state updates on the rising edge
//   reset       in  synchronous active-high reset
//   rd_en       in  NRD        per-port read enable
//   rd_addr     in  NRD*AW     packed read addresses, port i at [i*AW +: AW]
//   rd_data     out NRD*XLEN   packed read data, port i at [i*XLEN +: XLEN]
//   rd_pending  out NRD        source register of port i has an open claim
//   wr_en       in  1          write strobe
//   wr_addr     in  AW         write address
//   wr_data     in  XLEN       write data
//   claim_en    in  1          mark claim_addr pending
//   claim_addr  in  AW         register being claimed
//   init_done   out 1          clear sequence finished, traffic accepted
//   wr_drop     out 1          one-cycle pulse: a write/claim was discarded
//
// After reset the controller walks a counter over the whole array writing
// zeros (one register per cycle), so no read can ever return a value that was
// never written. Writes and claims arriving during that walk are discarded and
// reported on wr_drop the following cycle. Reads are combinational; a write
// presented in the same cycle is forwarded to matching read ports.
module rfile_mp
  import rfile_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int NREGS    = 32,
  parameter int NRD      = 2,
  parameter int ZERO_REG = 1,
  localparam int AW      = clog2(NREGS)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NRD-1:0]      rd_en,
  input  logic [NRD*AW-1:0]   rd_addr,
  output logic [NRD*XLEN-1:0] rd_data,
  output logic [NRD-1:0]      rd_pending,
  input  logic                wr_en,
  input  logic [AW-1:0]       wr_addr,
  input  logic [XLEN-1:0]     wr_data,
  input  logic                claim_en,
  input  logic [AW-1:0]       claim_addr,
  output logic                init_done,
  output logic                wr_drop
);

  // Register 0 is read-only when the zero register is enabled.
  function automatic logic is_writable(input logic [AW-1:0] addr);
    return !((ZERO_REG != 0) && (addr == '0));
  endfunction

  rf_state_t     state_reg;
  rf_state_t     state_next;
  logic [AW-1:0] cnt_reg;
  logic [AW-1:0] cnt_next;
  logic          wr_drop_reg;
  logic          wr_drop_next;

  logic [XLEN-1:0] mem [NREGS];
  logic            mem_we;
  logic [AW-1:0]   mem_waddr;
  logic [XLEN-1:0] mem_wdata;

  logic          in_ready;
  logic          wr_ok;
  logic          claim_ok;
  logic [NRD-1:0] sb_pend;

  assign in_ready = (state_reg == RF_READY);
  // wr_ok doubles as the bypass qualifier: only writes that will actually
  // land in the array may be forwarded to readers.
  assign wr_ok    = in_ready & wr_en & is_writable(wr_addr);
  assign claim_ok = in_ready & claim_en & is_writable(claim_addr);

  // ---------------------------------------------------------------------
  // Controller: next state, clear counter, array write port selection.
  // ---------------------------------------------------------------------
  always_comb begin
    state_next   = state_reg;
    cnt_next     = cnt_reg;
    wr_drop_next = 1'b0;
    mem_we       = 1'b0;
    mem_waddr    = wr_addr;
    mem_wdata    = wr_data;
    unique case (state_reg)
      RF_INIT: begin
        // The clear sequencer owns the write port; external strobes are lost.
        mem_we       = 1'b1;
        mem_waddr    = cnt_reg;
        mem_wdata    = '0;
        cnt_next     = cnt_reg + AW'(1);
        wr_drop_next = wr_en | claim_en;
        if (cnt_reg == AW'(NREGS - 1)) begin
          state_next = RF_READY;
        end
      end
      RF_READY: begin
        mem_we = wr_ok;
      end
      default: begin
        state_next = RF_INIT;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg   <= RF_INIT;
      cnt_reg     <= '0;
      wr_drop_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      wr_drop_reg <= wr_drop_next;
    end
  end

  // Array contents are not reset directly; the clear walk that follows
  // reset defines them. Writes are suppressed while reset is held.
  always_ff @(posedge clk) begin
    if (mem_we && !reset) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  // ---------------------------------------------------------------------
  // Pending scoreboard: claims set, writes clear (only once ready).
  // ---------------------------------------------------------------------
  rfile_scoreboard #(
    .NREGS    (NREGS),
    .NRD      (NRD),
    .ZERO_REG (ZERO_REG)
  ) u_scoreboard (
    .clk         (clk),
    .reset       (reset),
    .set_en      (claim_ok),
    .set_addr    (claim_addr),
    .clr_en      (wr_ok),
    .clr_addr    (wr_addr),
    .lookup_addr (rd_addr),
    .lookup_pend (sb_pend)
  );

  // ---------------------------------------------------------------------
  // Read ports with same-cycle write bypass.
  // ---------------------------------------------------------------------
  genvar gi;
  generate
    for (gi = 0; gi < NRD; gi++) begin : g_rd
      logic [AW-1:0] addr;
      logic          hit;
      logic          live;
      assign addr = rd_addr[gi*AW +: AW];
      assign hit  = wr_ok & (wr_addr == addr);
      assign live = rd_en[gi] & in_ready;
      assign rd_data[gi*XLEN +: XLEN] = !live ? '0 : (hit ? wr_data : mem[addr]);
      // A bypassed read already carries the awaited result, so it is not
      // reported as pending even though the bit clears only at the edge.
      assign rd_pending[gi] = live & sb_pend[gi] & ~hit;
    end
  endgenerate

  assign init_done = in_ready;
  assign wr_drop   = wr_drop_reg;

endmodule : rfile_mp

// File: tb/tb_rfile_mp.sv
// tb_rfile_mp -- self-checking bench for rfile_mp (XLEN=32, NREGS=32, NRD=2).
// Directed scenario tasks plus a randomized phase, all checked against a
// register-array/pending-array reference model kept in the bench.
`timescale 1ns/1ps
module tb_rfile_mp;

  localparam int XLEN  = 32;
  localparam int NREGS = 32;
  localparam int NRD   = 2;
  localparam int AW    = 5;

  logic                clk = 1'b0;
  logic                reset;
  logic [NRD-1:0]      rd_en;
  logic [NRD*AW-1:0]   rd_addr;
  logic [NRD*XLEN-1:0] rd_data;
  logic [NRD-1:0]      rd_pending;
  logic                wr_en;
  logic [AW-1:0]       wr_addr;
  logic [XLEN-1:0]     wr_data;
  logic                claim_en;
  logic [AW-1:0]       claim_addr;
  logic                init_done;
  logic                wr_drop;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model
  logic [XLEN-1:0] m_regs [NREGS];
  bit              m_pend [NREGS];
  bit              m_ready;
  int              m_cnt;
  bit              m_drop;

  always #5 clk = ~clk;

  rfile_mp #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .ZERO_REG(1)) dut (
    .clk        (clk),
    .reset      (reset),
    .rd_en      (rd_en),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .rd_pending (rd_pending),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .claim_en   (claim_en),
    .claim_addr (claim_addr),
    .init_done  (init_done),
    .wr_drop    (wr_drop)
  );

  // Advance one rising edge and apply the architectural rules to the model
  // using the inputs that were present at that edge.
  task automatic tick();
    @(posedge clk);
    if (reset) begin
      m_ready = 0;
      m_cnt   = 0;
      m_drop  = 0;
      for (int i = 0; i < NREGS; i++) m_pend[i] = 0;
    end else if (!m_ready) begin
      m_regs[m_cnt] = '0;
      m_drop = wr_en | claim_en;
      m_cnt++;
      if (m_cnt == NREGS) m_ready = 1;
    end else begin
      m_drop = 0;
      if (wr_en && wr_addr != 0) begin
        m_regs[wr_addr] = wr_data;
        m_pend[wr_addr] = 0;
      end
      if (claim_en && claim_addr != 0) m_pend[claim_addr] = 1;
    end
    #1;
  endtask

  function automatic logic [XLEN-1:0] exp_data(int p);
    logic [AW-1:0] a;
    a = rd_addr[p*AW +: AW];
    if (!rd_en[p] || !m_ready) return '0;
    if (a == 0) return '0;
    if (wr_en && wr_addr == a) return wr_data;
    return m_regs[a];
  endfunction

  function automatic logic exp_pend(int p);
    logic [AW-1:0] a;
    a = rd_addr[p*AW +: AW];
    if (!rd_en[p] || !m_ready || a == 0) return 1'b0;
    if (wr_en && wr_addr == a) return 1'b0;
    return m_pend[a];
  endfunction

  task automatic idle();
    wr_en = 0; wr_addr = '0; wr_data = '0;
    claim_en = 0; claim_addr = '0;
    rd_en = '0; rd_addr = '0;
  endtask

  task automatic set_rd(int p, logic [AW-1:0] a);
    rd_addr[p*AW +: AW] = a;
  endtask

  // -------------------------------------------------------------------
  task automatic test_reset();
    idle();
    reset = 1;
    rd_en = 2'b11;
    repeat (3) tick();
    $display("tx reset: held 3 cycles");
    n_checks++;
    if (init_done !== 1'b0 || wr_drop !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_flags: init_done=%b wr_drop=%b required 0 0", init_done, wr_drop);
    end
    n_checks++;
    if (rd_data !== '0 || rd_pending !== '0) begin
      n_fail++;
      $display("FAIL reset_reads: rd_data=%h rd_pending=%b required 0 0", rd_data, rd_pending);
    end
    reset = 0;
    for (int k = 1; k <= NREGS; k++) begin
      set_rd(0, AW'(k - 1));
      set_rd(1, AW'($urandom_range(0, NREGS - 1)));
      #1;
      n_checks++;
      if (rd_data !== '0) begin
        n_fail++;
        $display("FAIL init_read_zero: edge %0d rd_data=%h required 0", k, rd_data);
      end
      tick();
      n_checks++;
      if (init_done !== (k == NREGS)) begin
        n_fail++;
        $display("FAIL init_done_timing: edge %0d init_done=%b required %b", k, init_done, (k == NREGS));
      end
    end
    $display("tx init: %0d edges, init_done=%b", NREGS, init_done);
  endtask

  task automatic test_bypass();
    idle();
    wr_en = 1; wr_addr = 5; wr_data = 32'hDEADBEEF;
    rd_en = 2'b01; set_rd(0, 5);
    #1;
    n_checks++;
    if (rd_data[31:0] !== 32'hDEADBEEF) begin
      n_fail++;
      $display("FAIL bypass_same_cycle: rd_data0=%h required deadbeef", rd_data[31:0]);
    end
    tick();
    idle();
    rd_en = 2'b11; set_rd(0, 5); set_rd(1, 5);
    #1;
    n_checks++;
    if (rd_data !== {32'hDEADBEEF, 32'hDEADBEEF}) begin
      n_fail++;
      $display("FAIL bypass_array: rd_data=%h required deadbeefdeadbeef", rd_data);
    end
    $display("tx write x5=deadbeef, read back %h", rd_data[31:0]);
    tick();
  endtask

  task automatic test_zero_reg();
    idle();
    wr_en = 1; wr_addr = 0; wr_data = 32'h1234;
    claim_en = 1; claim_addr = 0;
    rd_en = 2'b11; set_rd(0, 0); set_rd(1, 0);
    #1;
    n_checks++;
    if (rd_data !== '0 || rd_pending !== '0) begin
      n_fail++;
      $display("FAIL zero_same_cycle: rd_data=%h rd_pending=%b required 0 0", rd_data, rd_pending);
    end
    tick();
    wr_en = 0; claim_en = 0;
    #1;
    n_checks++;
    if (rd_data !== '0 || rd_pending !== '0 || wr_drop !== 1'b0) begin
      n_fail++;
      $display("FAIL zero_after: rd_data=%h rd_pending=%b wr_drop=%b required 0 0 0",
               rd_data, rd_pending, wr_drop);
    end
    $display("tx write+claim x0, read %h pending %b", rd_data[31:0], rd_pending);
    tick();
  endtask

  task automatic test_pending();
    idle();
    claim_en = 1; claim_addr = 7;
    rd_en = 2'b01; set_rd(0, 7);
    tick();
    claim_en = 0;
    #1;
    n_checks++;
    if (rd_pending[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL pending_set: rd_pending0=%b required 1", rd_pending[0]);
    end
    wr_en = 1; wr_addr = 7; wr_data = 32'hFFFFFFFB;
    #1;
    n_checks++;
    if (rd_data[31:0] !== 32'hFFFFFFFB || rd_pending[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL pending_bypass: rd_data0=%h rd_pending0=%b required fffffffb 0",
               rd_data[31:0], rd_pending[0]);
    end
    tick();
    wr_en = 0;
    #1;
    n_checks++;
    if (rd_pending[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL pending_cleared: rd_pending0=%b required 0", rd_pending[0]);
    end
    wr_en = 1; wr_addr = 7; wr_data = 32'h11;
    claim_en = 1; claim_addr = 7;
    tick();
    wr_en = 0; claim_en = 0;
    #1;
    n_checks++;
    if (rd_pending[0] !== 1'b1 || rd_data[31:0] !== 32'h11) begin
      n_fail++;
      $display("FAIL claim_over_write: rd_pending0=%b rd_data0=%h required 1 00000011",
               rd_pending[0], rd_data[31:0]);
    end
    $display("tx claim/write x7, final pending %b data %h", rd_pending[0], rd_data[31:0]);
    tick();
  endtask

  task automatic test_init_drop();
    int budget;
    idle();
    reset = 1;
    tick();
    reset = 0;
    wr_en = 1; wr_addr = 9; wr_data = 32'hAAAA5555;
    tick();
    wr_en = 0;
    n_checks++;
    if (wr_drop !== 1'b1) begin
      n_fail++;
      $display("FAIL drop_pulse: wr_drop=%b required 1", wr_drop);
    end
    tick();
    n_checks++;
    if (wr_drop !== 1'b0) begin
      n_fail++;
      $display("FAIL drop_one_cycle: wr_drop=%b required 0", wr_drop);
    end
    budget = 0;
    while (init_done !== 1'b1 && budget < 64) begin
      tick();
      budget++;
    end
    n_checks++;
    if (init_done !== 1'b1) begin
      n_fail++;
      $display("FAIL drop_init_timeout: init_done=%b required 1", init_done);
    end
    rd_en = 2'b01; set_rd(0, 9);
    #1;
    n_checks++;
    if (rd_data[31:0] !== 32'h0) begin
      n_fail++;
      $display("FAIL drop_x9_zero: rd_data0=%h required 0", rd_data[31:0]);
    end
    $display("tx write x9 during init dropped, x9=%h", rd_data[31:0]);
    tick();
  endtask

  task automatic test_reset_mid_init();
    idle();
    claim_en = 1; claim_addr = 3;
    tick();
    claim_addr = 12;
    tick();
    claim_en = 0;
    reset = 1;
    tick();
    reset = 0;
    repeat (10) tick();
    reset = 1;
    tick();
    reset = 0;
    n_checks++;
    if (init_done !== 1'b0) begin
      n_fail++;
      $display("FAIL midinit_done_low: init_done=%b required 0", init_done);
    end
    for (int k = 1; k <= NREGS; k++) begin
      tick();
      n_checks++;
      if (init_done !== (k == NREGS)) begin
        n_fail++;
        $display("FAIL midinit_timing: edge %0d init_done=%b required %b", k, init_done, (k == NREGS));
      end
    end
    rd_en = 2'b11;
    for (int a = 0; a < NREGS; a += 2) begin
      set_rd(0, AW'(a));
      set_rd(1, AW'(a + 1));
      #1;
      n_checks++;
      if (rd_pending !== 2'b00 || rd_data !== '0) begin
        n_fail++;
        $display("FAIL midinit_clear: x%0d/x%0d pending=%b data=%h required 00 0",
                 a, a + 1, rd_pending, rd_data);
      end
    end
    $display("tx reset at counter 10, re-init complete, pending cleared");
    tick();
  endtask

  task automatic test_random();
    logic [XLEN-1:0] ed;
    logic            ep;
    for (int n = 0; n < 300; n++) begin
      idle();
      wr_en      = ($urandom_range(0, 99) < 50);
      wr_addr    = AW'($urandom_range(0, 7));
      wr_data    = $urandom;
      claim_en   = ($urandom_range(0, 99) < 35);
      claim_addr = AW'($urandom_range(0, 7));
      rd_en      = NRD'($urandom_range(0, 3));
      set_rd(0, AW'($urandom_range(0, 7)));
      set_rd(1, AW'($urandom_range(0, 7)));
      #1;
      for (int p = 0; p < NRD; p++) begin
        ed = exp_data(p);
        ep = exp_pend(p);
        n_checks++;
        if (rd_data[p*XLEN +: XLEN] !== ed || rd_pending[p] !== ep) begin
          n_fail++;
          $display("FAIL rand_read: cycle %0d port %0d data=%h pend=%b required %h %b",
                   n, p, rd_data[p*XLEN +: XLEN], rd_pending[p], ed, ep);
        end
      end
      $display("tx rand %0d: wr=%b x%0d=%h claim=%b x%0d rd=%b", n, wr_en, wr_addr, wr_data,
               claim_en, claim_addr, rd_en);
      tick();
      n_checks++;
      if (wr_drop !== m_drop) begin
        n_fail++;
        $display("FAIL rand_drop: cycle %0d wr_drop=%b required %b", n, wr_drop, m_drop);
      end
    end
  endtask

  initial begin
    reset = 1;
    m_ready = 0; m_cnt = 0; m_drop = 0;
    for (int i = 0; i < NREGS; i++) begin
      m_regs[i] = '0;
      m_pend[i] = 0;
    end
    idle();
    test_reset();
    test_bypass();
    test_zero_reg();
    test_pending();
    test_init_drop();
    test_reset_mid_init();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_rfile_mp
